// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: trigger-based trace capture for pipeline-latch contents.
// Each cycle in ARMED/POST it stores NCH channel words, their valid bits and a
// free-running cycle stamp into a circular buffer. It stops POST_TRIG samples
// after the trigger sample and then holds the window for indexed readout
// (index 0 = oldest stored entry).
module pipe_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int NCH       = 4,
  parameter int DEPTH     = 16,
  parameter int CYC_W     = 16,
  parameter int POST_TRIG = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  trig,
  input  logic [NCH*DATA_W-1:0] ch_data,
  input  logic [NCH-1:0]        ch_valid,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_idx,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic [NCH*DATA_W-1:0] rd_data,
  output logic [NCH-1:0]        rd_vmask,
  output logic [CYC_W-1:0]      rd_cycle,
  output logic [1:0]            state,
  output logic [AW:0]           count,
  output logic [AW-1:0]         trig_idx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [CYC_W-1:0]      stamp;
    logic [NCH-1:0]        vmask;
    logic [NCH*DATA_W-1:0] data;
  } entry_t;

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_C  = AW'(POST_TRIG);
  // Post-trigger countdown starts at POST_TRIG-1 so the sample written with
  // pc == 0 is exactly the POST_TRIG-th one after the trigger.
  localparam logic [AW-1:0] PC_LOAD = (POST_TRIG == 0) ? '0 : AW'(POST_TRIG - 1);

  state_t          cur_state, next_state;
  entry_t          mem [DEPTH];
  logic [CYC_W-1:0] cyc;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   pc;
  logic [AW:0]     count_inc;
  logic [AW-1:0]   trig_calc;
  logic [AW-1:0]   rd_addr;
  logic            capture_en;
  logic            arm_start;
  logic            enter_post;
  logic            last_write;
  logic            rd_ok;

  assign state = cur_state;

  // Saturating occupancy after this cycle's write, and the trigger position
  // within the final window (wraps mod DEPTH like every buffer index).
  assign count_inc = (count == DEPTH_C) ? count : count + (AW+1)'(1);
  assign trig_calc = count_inc[AW-1:0] - AW'(1) - POST_C;

  // Logical index 0 is the oldest entry: wptr - count, modulo DEPTH.
  assign rd_addr = wptr - count[AW-1:0] + rd_idx;
  assign rd_ok   = rd_en && (cur_state == ST_DONE) && ({1'b0, rd_idx} < count);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) cur_state <= ST_IDLE;
    else       cur_state <= next_state;
  end

  // Next-state logic; arm only acts from IDLE/DONE, trig only from ARMED.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    next_state = cur_state;
    case (cur_state)
      ST_IDLE:  if (arm) next_state = ST_ARMED;
      ST_ARMED: if (trig) next_state = (POST_TRIG == 0) ? ST_DONE : ST_POST;
      ST_POST:  if (pc == '0) next_state = ST_DONE;
      ST_DONE:  if (arm) next_state = ST_ARMED;
      default:  next_state = ST_IDLE;
    endcase
  end

  // FSM-decoded control strobes for the datapath.
  always_comb begin
    capture_en = (cur_state == ST_ARMED) || (cur_state == ST_POST);
    arm_start  = arm && ((cur_state == ST_IDLE) || (cur_state == ST_DONE));
    enter_post = (cur_state == ST_ARMED) && trig && (POST_TRIG != 0);
    last_write = ((cur_state == ST_ARMED) && trig && (POST_TRIG == 0)) ||
                 ((cur_state == ST_POST) && (pc == '0));
  end

  // Cycle stamp, write pointer, occupancy, post-trigger countdown, trigger index.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      cyc      <= '0;
      wptr     <= '0;
      count    <= '0;
      pc       <= '0;
      trig_idx <= '0;
    end else begin
      cyc <= cyc + CYC_W'(1);
      if (arm_start) begin
        wptr  <= '0;
        count <= '0;
      end else if (capture_en) begin
        wptr  <= wptr + AW'(1);
        count <= count_inc;
      end
      if (enter_post)                pc <= PC_LOAD;
      else if (cur_state == ST_POST) pc <= pc - AW'(1);
      if (last_write) trig_idx <= trig_calc;
    end
  end

  // Sample storage.
  always_ff @(posedge clock) begin
    // NOTE: the trace memory has no reset; its contents are only exposed through qualified reads.
    if (capture_en) mem[wptr] <= '{stamp: cyc, vmask: ch_valid, data: ch_data};
  end

  // Registered readout; rejected reads pulse rd_err and keep the old data.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
      rd_vmask <= '0;
      rd_cycle <= '0;
    end else begin
      rd_valid <= rd_ok;
      rd_err   <= rd_en && !rd_ok;
      if (rd_ok) begin
        rd_data  <= mem[rd_addr].data;
        rd_vmask <= mem[rd_addr].vmask;
        rd_cycle <= mem[rd_addr].stamp;
      end
    end
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Bench for pipe_trace_buffer: three instances sharing clock/reset/data/arm
// (main: POST_TRIG=3; pt0: POST_TRIG=0; wrap: CYC_W=4), each with its own trigger.
// Expected read results are queued when a read is issued and compared when
// the registered read outputs appear.
module tb_pipe_trace_buffer;

  localparam int DATA_W = 32;
  localparam int NCH    = 4;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int DW     = NCH * DATA_W;

  typedef struct {
    int             inst;
    logic           valid;
    logic           err;
    logic [15:0]    stamp;
    logic [DW-1:0]  data;
    logic [NCH-1:0] vmask;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           reset, arm, trig_m, trig_p, trig_w, rd_en;
  logic [AW-1:0]  rd_idx;
  logic [DW-1:0]  ch_data;
  logic [NCH-1:0] ch_valid;

  logic           rd_valid_m, rd_err_m, rd_valid_p, rd_err_p, rd_valid_w, rd_err_w;
  logic [DW-1:0]  rd_data_m, rd_data_p, rd_data_w;
  logic [NCH-1:0] rd_vmask_m, rd_vmask_p, rd_vmask_w;
  logic [15:0]    rd_cycle_m, rd_cycle_p;
  logic [3:0]     rd_cycle_w;
  logic [1:0]     state_m, state_p, state_w;
  logic [AW:0]    count_m, count_p, count_w;
  logic [AW-1:0]  trig_idx_m, trig_idx_p, trig_idx_w;

  pipe_trace_buffer #(.DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH), .CYC_W(16), .POST_TRIG(3)) u_main (
    .clock(clock), .reset(reset), .arm(arm), .trig(trig_m), .ch_data(ch_data), .ch_valid(ch_valid),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid_m), .rd_err(rd_err_m), .rd_data(rd_data_m),
    .rd_vmask(rd_vmask_m), .rd_cycle(rd_cycle_m), .state(state_m), .count(count_m), .trig_idx(trig_idx_m)
  );

  pipe_trace_buffer #(.DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH), .CYC_W(16), .POST_TRIG(0)) u_pt0 (
    .clock(clock), .reset(reset), .arm(arm), .trig(trig_p), .ch_data(ch_data), .ch_valid(ch_valid),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid_p), .rd_err(rd_err_p), .rd_data(rd_data_p),
    .rd_vmask(rd_vmask_p), .rd_cycle(rd_cycle_p), .state(state_p), .count(count_p), .trig_idx(trig_idx_p)
  );

  pipe_trace_buffer #(.DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH), .CYC_W(4), .POST_TRIG(3)) u_wrap (
    .clock(clock), .reset(reset), .arm(arm), .trig(trig_w), .ch_data(ch_data), .ch_valid(ch_valid),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid_w), .rd_err(rd_err_w), .rd_data(rd_data_w),
    .rd_vmask(rd_vmask_w), .rd_cycle(rd_cycle_w), .state(state_w), .count(count_w), .trig_idx(trig_idx_w)
  );

  int   cyc_m;   // model of the DUT cycle counter
  int   errors;
  int   checks;
  int   t0;
  exp_t sb[$];

  // Channel k carries {k, cyc[23:0]}.
  function automatic logic [DW-1:0] exp_data(input int c);
    logic [DW-1:0] d;
    logic [23:0]   lc;
    logic [7:0]    kb;
    lc = c[23:0];
    for (int k = 0; k < NCH; k++) begin
      kb = 8'(k);
      d[k*DATA_W +: DATA_W] = {kb, lc};
    end
    return d;
  endfunction

  function automatic logic [NCH-1:0] exp_vmask(input int c);
    return c[3:0] ^ 4'b0101;
  endfunction

  function automatic void push(input int inst, input logic v, input logic er,
                               input int stamp, input int dc);
    exp_t e;
    e.inst  = inst;
    e.valid = v;
    e.err   = er;
    e.stamp = 16'(stamp);
    e.data  = exp_data(dc);
    e.vmask = exp_vmask(dc);
    sb.push_back(e);
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: update the cycle model, then drive the next sample's data.
  task automatic tick();
    @(posedge clock);
    if (reset) cyc_m = 0;
    else       cyc_m = cyc_m + 1;
    #1;
    ch_data  = exp_data(cyc_m);
    ch_valid = exp_vmask(cyc_m);
  endtask

  // Compare every queued read expectation against the current read outputs.
  task automatic drain();
    exp_t           e;
    logic           ov, oe;
    logic [15:0]    oc;
    logic [DW-1:0]  od;
    logic [NCH-1:0] ovm;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.inst)
        0:       begin ov = rd_valid_m; oe = rd_err_m; oc = rd_cycle_m; od = rd_data_m; ovm = rd_vmask_m; end
        1:       begin ov = rd_valid_p; oe = rd_err_p; oc = rd_cycle_p; od = rd_data_p; ovm = rd_vmask_p; end
        default: begin ov = rd_valid_w; oe = rd_err_w; oc = {12'b0, rd_cycle_w}; od = rd_data_w; ovm = rd_vmask_w; end
      endcase
      check($sformatf("rd%0d_valid", e.inst), DW'(ov), DW'(e.valid));
      check($sformatf("rd%0d_err", e.inst), DW'(oe), DW'(e.err));
      check($sformatf("rd%0d_cycle", e.inst), DW'(oc), DW'(e.stamp));
      check($sformatf("rd%0d_data", e.inst), od, e.data);
      check($sformatf("rd%0d_vmask", e.inst), DW'(ovm), DW'(e.vmask));
    end
  endtask

  initial begin
    errors = 0; checks = 0; cyc_m = 0;
    reset = 1'b1; arm = 1'b0; trig_m = 1'b0; trig_p = 1'b0; trig_w = 1'b0;
    rd_en = 1'b0; rd_idx = '0;
    ch_data = exp_data(0); ch_valid = exp_vmask(0);

    // Reset state.
    tick(); tick();
    reset = 1'b0;
    check("rst_state", DW'(state_m), DW'(0));
    check("rst_count", DW'(count_m), DW'(0));
    check("rst_trig_idx", DW'(trig_idx_m), DW'(0));
    check("rst_rd_valid", DW'(rd_valid_m), DW'(0));
    check("rst_rd_err", DW'(rd_err_m), DW'(0));
    check("rst_rd_data", rd_data_m, '0);
    check("rst_rd_cycle", DW'(rd_cycle_m), DW'(0));

    // Trigger in IDLE is ignored.
    trig_m = 1'b1; trig_p = 1'b1; trig_w = 1'b1;
    tick();
    trig_m = 1'b0; trig_p = 1'b0; trig_w = 1'b0;
    check("idle_trig_m", DW'(state_m), DW'(0));
    check("idle_trig_p", DW'(state_p), DW'(0));

    // Arm in cycle 1: capture starts with the cycle-2 sample.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("armed_state", DW'(state_m), DW'(1));
    check("armed_count", DW'(count_m), DW'(0));

    // Capture run: pt0 triggers at 10, wrap at 14, main at 20.
    while (cyc_m < 24) begin
      trig_m = (cyc_m == 20);
      trig_p = (cyc_m == 10);
      trig_w = (cyc_m == 14);
      rd_en  = (cyc_m == 6);
      tick();
      trig_m = 1'b0; trig_p = 1'b0; trig_w = 1'b0; rd_en = 1'b0;
      if (cyc_m == 6)  check("count_at6", DW'(count_m), DW'(4));
      if (cyc_m == 7) begin
        check("armed_rd_err", DW'(rd_err_m), DW'(1));
        check("armed_rd_valid", DW'(rd_valid_m), DW'(0));
      end
      if (cyc_m == 10) begin
        check("count_sat_at10", DW'(count_m), DW'(8));
        check("pt0_still_armed", DW'(state_p), DW'(1));
      end
      if (cyc_m == 11) begin
        check("count_sat_at11", DW'(count_m), DW'(8));
        check("pt0_done", DW'(state_p), DW'(3));
        check("pt0_count", DW'(count_p), DW'(8));
        check("pt0_trig_idx", DW'(trig_idx_p), DW'(7));
      end
      if (cyc_m == 15) check("wrap_post", DW'(state_w), DW'(2));
      if (cyc_m == 18) begin
        check("wrap_done", DW'(state_w), DW'(3));
        check("wrap_trig_idx", DW'(trig_idx_w), DW'(4));
      end
      if (cyc_m == 21 || cyc_m == 23) check($sformatf("main_post_%0d", cyc_m), DW'(state_m), DW'(2));
    end
    check("main_done", DW'(state_m), DW'(3));
    check("main_count", DW'(count_m), DW'(8));
    check("main_trig_idx", DW'(trig_idx_m), DW'(4));

    // Back-to-back reads of every entry from all three frozen buffers.
    for (int i = 0; i < DEPTH; i++) begin
      rd_en  = 1'b1;
      rd_idx = AW'(i);
      push(0, 1'b1, 1'b0, 16 + i, 16 + i);
      push(1, 1'b1, 1'b0, 3 + i, 3 + i);
      push(2, 1'b1, 1'b0, (10 + i) % 16, 10 + i);
      tick();
      drain();
    end
    rd_en = 1'b0;
    tick();
    check("rd_valid_pulse", DW'(rd_valid_m), DW'(0));
    check("rd_err_idle", DW'(rd_err_m), DW'(0));

    // arm+trig in DONE: arm only; concurrent read served from the frozen buffer.
    arm = 1'b1; trig_m = 1'b1; rd_en = 1'b1; rd_idx = 3'd7;
    push(0, 1'b1, 1'b0, 23, 23);
    push(1, 1'b1, 1'b0, 10, 10);
    push(2, 1'b1, 1'b0, 1, 17);
    tick();
    arm = 1'b0; trig_m = 1'b0; rd_en = 1'b0;
    drain();
    check("rearm_state", DW'(state_m), DW'(1));
    check("rearm_count", DW'(count_m), DW'(0));
    t0 = cyc_m;

    // Early trigger: two pre-trigger samples, trigger at t0+2.
    tick(); tick();
    trig_m = 1'b1;
    tick();
    trig_m = 1'b0;
    check("early_post", DW'(state_m), DW'(2));
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("post_arm_state", DW'(state_m), DW'(2));
    check("post_arm_count", DW'(count_m), DW'(4));
    tick(); tick();
    check("early_done", DW'(state_m), DW'(3));
    check("early_count", DW'(count_m), DW'(6));
    check("early_trig_idx", DW'(trig_idx_m), DW'(2));
    rd_en = 1'b1; rd_idx = 3'd2;
    push(0, 1'b1, 1'b0, t0 + 2, t0 + 2);
    tick();
    drain();
    rd_idx = 3'd6;
    push(0, 1'b0, 1'b1, t0 + 2, t0 + 2);
    tick();
    rd_en = 1'b0;
    drain();

    // Reset during POST aborts the capture and clears read outputs.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    trig_m = 1'b1;
    tick();
    trig_m = 1'b0;
    check("pre_reset_post", DW'(state_m), DW'(2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_state", DW'(state_m), DW'(0));
    check("mid_rst_count", DW'(count_m), DW'(0));
    check("mid_rst_trig_idx", DW'(trig_idx_m), DW'(0));
    check("mid_rst_rd_data", rd_data_m, '0);
    check("mid_rst_rd_cycle", DW'(rd_cycle_m), DW'(0));
    check("mid_rst_rd_vmask", DW'(rd_vmask_m), DW'(0));

    // Trigger on the first armed sample: zero pre-trigger depth; stamps restart at 0.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig_m = 1'b1;
    tick();
    trig_m = 1'b0;
    tick(); tick(); tick();
    check("zero_pre_done", DW'(state_m), DW'(3));
    check("zero_pre_count", DW'(count_m), DW'(4));
    check("zero_pre_trig_idx", DW'(trig_idx_m), DW'(0));
    rd_en = 1'b1; rd_idx = 3'd0;
    push(0, 1'b1, 1'b0, 1, 1);
    tick();
    drain();
    rd_idx = 3'd3;
    push(0, 1'b1, 1'b0, 4, 4);
    tick();
    rd_en = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_trace_buffer.md
# pipe_trace_buffer

Synthesizable trace capture for pipeline-latch contents. Each cycle it records NCH channel words (one per pipeline register, e.g. IF/ID, ID/EX, EX/MEM, MEM/WB), their valid bits and a free-running cycle stamp into a circular buffer. It stops a programmable number of samples after a trigger, then holds the capture for indexed readout. It sits beside the MIPS pipeline core and replaces per-cycle console dumps with an on-chip trigger/post-trigger window.

## Interface
- DATA_W, 32, width of one channel word
- NCH, 4, number of channels (pipeline stages); ≥1
- DEPTH, 16, entries; power of two, ≥2; AW = log2(DEPTH)
- CYC_W, 16, cycle-stamp width
- POST_TRIG, 8, samples captured after the trigger sample; 0..DEPTH-1
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- arm  in  1  start a new capture
- trig  in  1  trigger event
- ch_data  in  NCH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
- ch_valid  in  NCH  per-channel valid
- rd_en  in  1  read request
- rd_idx  in  AW  index relative to oldest entry (0 = oldest)
- rd_valid  out  1  read data valid
- rd_err  out  1  read rejected
- rd_data  out  NCH*DATA_W  stored channel words
- rd_vmask  out  NCH  stored valid bits
- rd_cycle  out  CYC_W  stored cycle stamp
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- count  out  AW+1  valid entries, saturates at DEPTH
- trig_idx  out  AW  index of the trigger sample, valid in DONE

## Operation
- cyc: CYC_W counter. Increments every cycle and wraps from 2^CYC_W-1 to 0. It is not cleared by arm.
- FSM:
  - IDLE: arm -> ARMED. trig is ignored.
  - ARMED: captures every cycle. trig -> POST, or -> DONE directly if POST_TRIG=0. arm is ignored.
  - POST: captures every cycle. An internal counter pc is loaded with POST_TRIG-1 on entry. When the sample with pc=0 is written -> DONE. arm and trig are ignored.
  - DONE: no capture. arm -> ARMED. trig is ignored.
- Capture: in ARMED and POST, on each rising edge, entry[wptr] <= {cyc, ch_valid, ch_data}, wptr <= wptr+1 mod DEPTH, count <= min(count+1, DEPTH). Old entries are overwritten on wrap.
- The sample written in the trigger cycle is the trigger sample.
- Total post-trigger samples equal POST_TRIG exactly.
- arm (from IDLE or DONE) resets count to 0 and wptr to 0. It does not clear memory contents.
- On entry to DONE: trig_idx <= count_final-1-POST_TRIG. If the trigger came before POST_TRIG... the window is never truncated; pre-trigger depth is count_final-1-POST_TRIG and may be 0.
- Read: physical address = (wptr - count + rd_idx) mod DEPTH.
  - Accepted only in DONE with rd_idx < count.
  - Otherwise rd_err=1, rd_valid=0, and data outputs keep their previous values.
- Simultaneous arm+trig in IDLE/DONE: arm only. The trigger is not seen, because state is not yet ARMED.
- Simultaneous rd_en and arm in DONE: the read is served from the frozen buffer, using pre-arm count and wptr.

## Timing
- Reset (synchronous) sets state=IDLE, cyc=0, count=0, wptr=0, trig_idx=0, rd_valid=0, rd_err=0, rd_data=0, rd_vmask=0, rd_cycle=0. Memory contents are undefined.
- Reset mid-capture aborts immediately; the next cycle is IDLE.
- Capture latency: ch_data sampled at edge N is readable after DONE. rd_cycle equals the cyc value before edge N.
- Read latency is 1 cycle: rd_en at edge N -> rd_valid/rd_err and data are registered at edge N. rd_valid and rd_err are single-cycle pulses.
- Back-to-back reads are permitted every cycle.
- POST→DONE: state reads DONE in the cycle after the last post-trigger sample is written.
- Throughput: one sample per clock, no stalls.

## Test plan
- DEPTH=8, POST_TRIG=3. Drive ch_data channel k = {k[7:0], cyc[23:0]}. Arm at cyc=2, trig at cyc=20 -> DONE at cyc=24; count=8; trig_idx=4. rd_idx 0..7 gives rd_cycle 16..23; rd_idx=4 gives cycle 20.
- Early trigger: arm at cyc=2, trig at cyc=4, POST_TRIG=3 -> count=6, trig_idx=2. rd_idx=6 gives rd_err=1, rd_valid=0.
- POST_TRIG=0: trig at cyc=10 -> DONE the next cycle. The last entry has rd_cycle=10, and trig_idx=count-1.
- Ignored events: trig in IDLE -> state stays 0. arm in POST -> no restart. arm+trig together in DONE -> ARMED, count=0. rd_en while ARMED -> rd_err=1.
- Reset at cyc=15 during POST -> next cycle state=0, count=0, cyc=0, and all read outputs are 0.
- CYC_W=4: run 20 cycles armed -> rd_cycle wraps 15 to 0 between consecutive entries.
